// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the 4-bit-opcode RV32 ALU: decodes RV32I integer-computational
// instructions into operands/op/rd/we and holds them in a two-entry skid buffer.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_op,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned OPW  = 4;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [OPW-1:0] ALU_ADD  = 4'h0;
    localparam logic [OPW-1:0] ALU_SUB  = 4'h1;
    localparam logic [OPW-1:0] ALU_AND  = 4'h2;
    localparam logic [OPW-1:0] ALU_OR   = 4'h3;
    localparam logic [OPW-1:0] ALU_XOR  = 4'h4;
    localparam logic [OPW-1:0] ALU_SLL  = 4'h5;
    localparam logic [OPW-1:0] ALU_SRL  = 4'h6;
    localparam logic [OPW-1:0] ALU_SRA  = 4'h7;
    localparam logic [OPW-1:0] ALU_SLT  = 4'h8;
    localparam logic [OPW-1:0] ALU_SLTU = 4'h9;
    localparam logic [OPW-1:0] ALU_ILL  = 4'hF;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [OPW-1:0]  op;
        logic [RW-1:0]   rd;
        logic            we;
        logic            illegal;
    } entry_t;

    // funct3 to ALU op for the forms that have no funct7 alternate
    function automatic logic [OPW-1:0] base_op(input logic [2:0] f3);
        logic [OPW-1:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign shamt  = XLEN'(in_instr[24:20]);

    entry_t dec_c;
    logic   legal_c;

    // Instruction decode into a buffer entry
    always_comb begin
        dec_c    = '0;
        legal_c  = 1'b0;
        dec_c.rd = in_instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec_c.a = in_rs1_val;
                dec_c.b = in_rs2_val;
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE) begin
                            legal_c  = 1'b1;
                            dec_c.op = ALU_ADD;
                        end else if (funct7 == F7_ALT) begin
                            legal_c  = 1'b1;
                            dec_c.op = ALU_SUB;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            legal_c  = 1'b1;
                            dec_c.op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            legal_c  = 1'b1;
                            dec_c.op = ALU_SRA;
                        end
                    end
                    default: begin
                        if (funct7 == F7_BASE) begin
                            legal_c  = 1'b1;
                            dec_c.op = base_op(funct3);
                        end
                    end
                endcase
            end
            OPC_OPIMM: begin
                dec_c.a = in_rs1_val;
                case (funct3)
                    3'b001: begin
                        dec_c.b = shamt;
                        if (funct7 == F7_BASE) begin
                            legal_c  = 1'b1;
                            dec_c.op = ALU_SLL;
                        end
                    end
                    3'b101: begin
                        dec_c.b = shamt;
                        if (funct7 == F7_BASE) begin
                            legal_c  = 1'b1;
                            dec_c.op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            legal_c  = 1'b1;
                            dec_c.op = ALU_SRA;
                        end
                    end
                    default: begin
                        legal_c  = 1'b1;
                        dec_c.b  = imm_i;
                        dec_c.op = base_op(funct3);
                    end
                endcase
            end
            OPC_LUI: begin
                legal_c  = 1'b1;
                dec_c.a  = '0;
                dec_c.b  = imm_u;
                dec_c.op = ALU_ADD;
            end
            OPC_AUIPC: begin
                legal_c  = 1'b1;
                dec_c.a  = in_pc;
                dec_c.b  = imm_u;
                dec_c.op = ALU_ADD;
            end
            default: legal_c = 1'b0;
        endcase

        if (legal_c) begin
            dec_c.we      = (dec_c.rd != '0);
            dec_c.illegal = 1'b0;
        end else begin
            dec_c.a       = '0;
            dec_c.b       = '0;
            dec_c.op      = ALU_ILL;
            dec_c.we      = 1'b0;
            dec_c.illegal = 1'b1;
        end
    end

    logic   m_valid_q, m_valid_d;
    logic   s_valid_q, s_valid_d;
    entry_t m_q, m_d;
    entry_t s_q, s_d;
    logic   accept_c;
    logic   m_free_c;

    assign accept_c = in_valid && !s_valid_q;
    assign m_free_c = !m_valid_q || out_ready;

    // Skid-buffer next state; flush overrides every other update
    always_comb begin
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        m_d       = m_q;
        s_d       = s_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (m_free_c) begin
            if (s_valid_q) begin
                m_d       = s_q;
                m_valid_d = 1'b1;
                s_valid_d = 1'b0;
            end else if (accept_c) begin
                m_d       = dec_c;
                m_valid_d = 1'b1;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept_c) begin
            s_d       = dec_c;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_q       <= '0;
            s_q       <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_q       <= m_d;
            s_q       <= s_d;
        end
    end

    assign in_ready    = !s_valid_q;
    assign out_valid   = m_valid_q;
    assign out_a       = m_q.a;
    assign out_b       = m_q.b;
    assign out_op      = m_q.op;
    assign out_rd      = m_q.rd;
    assign out_we      = m_q.we;
    assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed plan items plus random traffic, scoreboarded
// against a reference decoder written from the instruction-set rules.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_val;
    logic [31:0] in_rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_op;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    alu_issue_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
        .out_we(out_we), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference decoder: funct3 selects the operation, funct7=0100000 selects the
    // alternate (sub / sra), which is numbered one above its base operation.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        int unsigned tbl[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
        exp_t        e = '0;
        bit          legal = 0;
        logic [6:0]  opc = ins[6:0];
        int unsigned f3 = int'(ins[14:12]);
        logic [6:0]  f7 = ins[31:25];
        bit          has_alt = (f3 == 0) || (f3 == 5);
        e.rd = ins[11:7];
        if (opc == 7'h33) begin
            e.a = r1;
            e.b = r2;
            legal = (f7 == 7'h00) || (f7 == 7'h20 && has_alt);
            e.op = 4'(tbl[f3] + ((f7 == 7'h20) ? 1 : 0));
        end else if (opc == 7'h13) begin
            e.a = r1;
            if (f3 == 1 || f3 == 5) begin
                e.b = {27'd0, ins[24:20]};
                legal = (f7 == 7'h00) || (f7 == 7'h20 && f3 == 5);
                e.op = 4'(tbl[f3] + ((f7 == 7'h20) ? 1 : 0));
            end else begin
                e.b = 32'($signed(ins[31:20]));
                legal = 1;
                e.op = 4'(tbl[f3]);
            end
        end else if (opc == 7'h37 || opc == 7'h17) begin
            e.a = (opc == 7'h17) ? pc : 32'd0;
            e.b = ins & 32'hFFFF_F000;
            e.op = 4'd0;
            legal = 1;
        end
        if (legal) begin
            e.we = (e.rd != 0);
        end else begin
            e.a = 0;
            e.b = 0;
            e.op = 4'hF;
            e.we = 0;
            e.ill = 1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Compares every presented output against the scoreboard head; pops on transfer
    task automatic monitor();
        exp_t act;
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                act = {out_a, out_b, out_op, out_rd, out_we, out_illegal};
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: got output %h want none", act);
                end else begin
                    if (act !== sb[0]) begin
                        errors++;
                        $display("FAIL out_entry: got %h want %h", act, sb[0]);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic ordy, input logic fl);
        in_valid   = v;
        in_instr   = ins;
        in_pc      = pc;
        in_rs1_val = r1;
        in_rs2_val = r2;
        out_ready  = ordy;
        flush      = fl;
    endtask

    // Records what the coming edge will accept (or discard on flush)
    task automatic settle();
        @(negedge clk);
        #1;
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(model(in_instr, in_pc, in_rs1_val, in_rs2_val));
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic ordy, input logic fl);
        next_cycle();
        drive(v, ins, pc, r1, r2, ordy, fl);
        settle();
    endtask

    task automatic directed(input string name, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] r1, input logic [31:0] r2,
                            input logic [31:0] ea, input logic [31:0] eb, input logic [3:0] eop,
                            input logic [4:0] erd, input logic ewe, input logic eill);
        step(1'b1, ins, pc, r1, r2, 1'b1, 1'b0);
        next_cycle();
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_a"}, out_a, ea);
        chk({name, "_b"}, out_b, eb);
        chk({name, "_op"}, 32'(out_op), 32'(eop));
        chk({name, "_rd"}, 32'(out_rd), 32'(erd));
        chk({name, "_we"}, 32'(out_we), 32'(ewe));
        chk({name, "_ill"}, 32'(out_illegal), 32'(eill));
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        settle();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_ready"}, 32'(in_ready), 32'd1);
        chk({name, "_a"}, out_a, 32'd0);
        chk({name, "_b"}, out_b, 32'd0);
        chk({name, "_misc"}, {23'd0, out_op, out_rd, out_we, out_illegal}, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  f7;
        case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 5))
            0:       return {f7, r[24:7], 7'h33};
            1:       return {r[31:7], 7'h13};
            2:       return {f7, r[24:15], (r[0] ? 3'b001 : 3'b101), r[11:7], 7'h13};
            3:       return {r[31:7], 7'h37};
            4:       return {r[31:7], 7'h17};
            default: return r;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] add_i;
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        fork
            monitor();
        join_none
        #3;
        chk_all_zero("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        directed("add", 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 4'h0, 5'd3, 1'b1, 1'b0);
        directed("sub", 32'h402081B3, 32'h0, 32'd5, 32'd7, 32'd5, 32'd7, 4'h1, 5'd3, 1'b1, 1'b0);
        directed("srai", 32'h40335293, 32'h0, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd3, 4'h7, 5'd5, 1'b1, 1'b0);
        directed("lui", 32'h123450B7, 32'h0, 32'd9, 32'd9, 32'd0, 32'h1234_5000, 4'h0, 5'd1, 1'b1, 1'b0);
        directed("auipc", 32'h12345097, 32'h100, 32'd9, 32'd9, 32'h100, 32'h1234_5000, 4'h0, 5'd1, 1'b1, 1'b0);
        directed("addi_x0", 32'h00100013, 32'h0, 32'd9, 32'd0, 32'd9, 32'd1, 4'h0, 5'd0, 1'b0, 1'b0);
        directed("illegal", 32'hFFFF_FFFF, 32'h0, 32'd9, 32'd9, 32'd0, 32'd0, 4'hF, 5'd31, 1'b0, 1'b1);

        // Backpressure: out_ready low for three cycles while streaming four adds
        add_i = 32'h002081B3;
        next_cycle(); chk("bp_rdy1", 32'(in_ready), 32'd1);
        drive(1'b1, {add_i[31:12], 5'd1, add_i[6:0]}, 0, 32'd11, 32'd1, 1'b0, 1'b0); settle();
        next_cycle(); chk("bp_rdy2", 32'(in_ready), 32'd1);
        drive(1'b1, {add_i[31:12], 5'd2, add_i[6:0]}, 0, 32'd22, 32'd2, 1'b0, 1'b0); settle();
        next_cycle(); chk("bp_rdy3", 32'(in_ready), 32'd0);
        drive(1'b1, {add_i[31:12], 5'd3, add_i[6:0]}, 0, 32'd33, 32'd3, 1'b0, 1'b0); settle();
        next_cycle(); chk("bp_rdy4", 32'(in_ready), 32'd0);
        drive(1'b1, {add_i[31:12], 5'd3, add_i[6:0]}, 0, 32'd33, 32'd3, 1'b1, 1'b0); settle();
        next_cycle(); chk("bp_rdy5", 32'(in_ready), 32'd1);
        drive(1'b1, {add_i[31:12], 5'd3, add_i[6:0]}, 0, 32'd33, 32'd3, 1'b1, 1'b0); settle();
        step(1'b1, {add_i[31:12], 5'd4, add_i[6:0]}, 0, 32'd44, 32'd4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Flush with both entries full and a concurrent request
        step(1'b1, add_i, 0, 32'd1, 32'd1, 1'b0, 1'b0);
        step(1'b1, add_i, 0, 32'd2, 32'd2, 1'b0, 1'b0);
        step(1'b1, add_i, 0, 32'd3, 32'd3, 1'b0, 1'b1);
        next_cycle();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);
        drive(1'b1, add_i, 0, 32'd4, 32'd4, 1'b1, 1'b1); settle();
        next_cycle();
        chk("flush_accept_dropped", 32'(out_valid), 32'd0);
        drive(1'b0, 0, 0, 0, 0, 1'b1, 1'b0); settle();

        // Asynchronous reset mid-stream
        step(1'b1, 32'h40335293, 0, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);
        step(1'b1, 32'h123450B7, 0, 32'd1, 32'd1, 1'b0, 1'b0);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_all_zero("midrst");
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        next_cycle();
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        drive(1'b0, 0, 0, 0, 0, 1'b1, 1'b0); settle();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), rand_instr(), $urandom, $urandom, $urandom,
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
        end
        for (int i = 0; i < 20 && sb.size() != 0; i++) step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        step(1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
